bbmips_fetch: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation bbmips core. It replaces the single-cycle PC/+4/ROM path.
- Generates sequential fetch addresses and talks to instruction memory over a req/ack handshake that tolerates wait states.
- Buffers fetched words in a DEPTH-entry prefetch queue of {pc, instr} pairs and presents them to decode with valid/ready.
- Supports branch/jump redirect with queue flush, and halting via the run flag from the syscall unit.

---
 rtl/bbmips_pkg.sv | 24 ++
 rtl/bbmips_fetch_queue.sv | 93 +++++++++
 rtl/bbmips_fetch.sv | 156 +++++++++++++++
 tb/tb_bbmips_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bbmips_pkg.sv
// bbmips_pkg: shared types and constants for the bbmips fetch front end.
//   XLEN          default address/instruction width
//   INSTR_BYTES   bytes per instruction word (sequential PC step)
//   fetch_state_t fetch FSM states
//   fetch_entry_t {pc, instr} prefetch queue payload
package bbmips_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  // IDLE: no request; BUSY: request whose data is kept; DROP: request whose
  // data is thrown away because a redirect flushed it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/bbmips_fetch_queue.sv
// bbmips_fetch_queue: synchronous DEPTH-entry FIFO of fetch_entry_t.
// Head, valid and count are registered; the next head is computed ahead of
// the edge so a word pushed into an empty queue is visible the next cycle.
//   i_clk, i_rst     clock, synchronous active-low reset
//   i_push/_data     write one entry (caller guarantees queue not full)
//   i_pop            advance head (ignored when empty)
//   i_flush          empty the queue; overrides push and pop
//   o_valid, o_head  head entry, zero when empty
//   o_count          number of stored entries
module bbmips_fetch_queue
  import bbmips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic                         o_valid,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  fetch_entry_t     r_head;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_left;
  logic [CNT_W-1:0] w_count_nxt;
  fetch_entry_t     w_head_nxt;

  // Next pointers, count and head entry.
  always_comb begin
    w_push       = i_push & ~i_flush;
    w_pop        = i_pop & r_valid & ~i_flush;
    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    w_count_left = r_count - CNT_W'(w_pop);
    w_count_nxt  = w_count_left + CNT_W'(w_push);
    w_head_nxt   = '0;
    if (i_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else if (w_count_left != '0) begin
      // Next head is already stored (it is older than any word written now).
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end else if (w_push) begin
      w_head_nxt = i_push_data;
    end
  end

  // Control state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_head   <= w_head_nxt;
    end
  end

  // Storage array; contents are qualified by the count, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/bbmips_fetch.sv
// bbmips_fetch: instruction-fetch front end. Issues sequential word fetches
// over a req/ack memory handshake, buffers {pc, instr} in a prefetch queue
// and hands them to decode with valid/ready. Redirects flush and restart.
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_run                 allow new fetch requests
//   i_redirect/_pc        flush and restart at the word-aligned target
//   o_imem_req/_addr      fetch request, held until i_imem_ack
//   i_imem_ack/_data      memory accept with returned instruction word
//   o_valid, i_ready      decode handshake on the queue head
//   o_pc, o_instr         head entry, zero when empty
//   o_busy                request outstanding or queue non-empty
module bbmips_fetch
  import bbmips_pkg::*;
#(
  parameter int unsigned     XLEN     = bbmips_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_run,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  output logic            o_busy
);

  localparam int unsigned     CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned     ENTRY_W = bbmips_pkg::XLEN;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] w_fpc_nxt;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;
  logic            r_busy;

  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_after;
  logic             w_slot_free;
  logic [XLEN-1:0]  w_redirect_pc;
  fetch_entry_t     w_push_entry;
  logic             w_q_valid;
  fetch_entry_t     w_q_head;
  logic [CNT_W-1:0] w_q_count;

  assign w_redirect_pc = i_redirect_pc & ~XLEN'(3);

  // Redirect outranks push and pop; a DROP-state ack never pushes.
  assign w_push = (r_state == BUSY) & i_imem_ack & ~i_redirect;
  assign w_pop  = w_q_valid & i_ready & ~i_redirect;

  // Queue occupancy after this edge; the free-slot test keeps
  // count + outstanding within DEPTH.
  assign w_cnt_after = i_redirect ? '0
                     : (w_q_count + CNT_W'(w_push) - CNT_W'(w_pop));
  assign w_slot_free = (w_cnt_after < CNT_W'(DEPTH));

  assign w_push_entry.pc    = ENTRY_W'(r_fpc);
  assign w_push_entry.instr = ENTRY_W'(i_imem_data);

  // Next-state, next fetch PC and issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_issue     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_run && (i_redirect || (w_q_count < CNT_W'(DEPTH)))) begin
          w_state_nxt = BUSY;
          w_issue     = 1'b1;
        end
      end
      BUSY, DROP: begin
        if (i_imem_ack) begin
          if (i_run && w_slot_free) begin
            w_state_nxt = BUSY;
            w_issue     = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (i_redirect) begin
          // Old address stays on the bus until memory acks it.
          w_state_nxt = DROP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (i_redirect) begin
      w_fpc_nxt = w_redirect_pc;
    end else if (w_push) begin
      w_fpc_nxt = r_fpc + PC_STEP;
    end
  end

  // FSM state and fetch PC.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_fpc   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
    end
  end

  // Registered memory-side and status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_busy      <= 1'b0;
    end else begin
      r_imem_req <= (w_state_nxt != IDLE);
      if (w_issue) begin
        r_imem_addr <= w_fpc_nxt;
      end
      r_busy <= (w_state_nxt != IDLE) || (w_cnt_after != '0);
    end
  end

  bbmips_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .o_valid     (w_q_valid),
    .o_head      (w_q_head),
    .o_count     (w_q_count)
  );

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_imem_addr;
  assign o_valid     = w_q_valid;
  assign o_pc        = XLEN'(w_q_head.pc);
  assign o_instr     = XLEN'(w_q_head.instr);
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_bbmips_fetch.sv
// tb_bbmips_fetch: directed bench for bbmips_fetch (XLEN=32, DEPTH=4).
// A small memory model acks after mem_wait wait cycles and returns
// addr ^ 32'hDEAD_0000; expected values below are hand-computed constants.
module tb_bbmips_fetch;

  logic        clk;
  logic        rst;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        busy;

  logic mem_en;
  int   mem_wait;
  int   wait_cnt;
  int   ack_cnt;
  int   n_assert;
  int   n_fail;

  bbmips_fetch #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_run         (run),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_data   (imem_data),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_pc          (pc),
    .o_instr       (instr),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack once the request has waited mem_wait cycles.
  assign imem_ack  = mem_en && imem_req && (wait_cnt >= mem_wait);
  assign imem_data = imem_addr ^ 32'hDEAD_0000;

  always @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 0;
      ack_cnt  <= 0;
    end else if (imem_ack) begin
      wait_cnt <= 0;
      ack_cnt  <= ack_cnt + 1;
    end else if (imem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ready = 1'b0; mem_en = 1'b1; mem_wait = 0;

    // Reset state
    tick(); tick();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr,     32'h0);
    check("rst_valid", 32'(valid),    32'd0);
    check("rst_pc",    pc,            32'h0);
    check("rst_instr", instr,         32'h0);
    check("rst_busy",  32'(busy),     32'd0);

    // Streaming fetch with zero-wait memory, decode always ready
    rst = 1'b1; run = 1'b1; ready = 1'b1; mem_wait = 0;
    tick();
    check("t1_req",    32'(imem_req), 32'd1);
    check("t1_addr0",  imem_addr,     32'h0);
    check("t1_valid0", 32'(valid),    32'd0);
    tick();
    check("t1_addr4",  imem_addr,     32'h4);
    check("t1_valid1", 32'(valid),    32'd1);
    check("t1_pc0",    pc,            32'h0);
    check("t1_ins0",   instr,         32'hDEAD_0000);
    tick();
    check("t1_addr8",  imem_addr,     32'h8);
    check("t1_pc4",    pc,            32'h4);
    check("t1_ins4",   instr,         32'hDEAD_0004);
    tick();
    check("t1_addrC",  imem_addr,     32'hC);
    check("t1_pc8",    pc,            32'h8);
    tick();
    check("t1_valid4", 32'(valid),    32'd1);
    check("t1_pcC",    pc,            32'hC);
    check("t1_insC",   instr,         32'hDEAD_000C);

    // Reset mid-request, then fill the queue with decode stalled
    rst = 1'b0; run = 1'b0; ready = 1'b0;
    tick();
    check("t2_rst_req",   32'(imem_req), 32'd0);
    check("t2_rst_valid", 32'(valid),    32'd0);
    rst = 1'b1; run = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("t2_full_req",  32'(imem_req), 32'd0);
    check("t2_full_acks", 32'(ack_cnt),  32'd4);
    check("t2_full_pc",   pc,            32'h0);
    check("t2_full_busy", 32'(busy),     32'd1);
    tick(); tick();
    check("t2_hold_acks", 32'(ack_cnt),  32'd4);
    check("t2_hold_req",  32'(imem_req), 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t2_pop_pc",    pc,            32'h4);
    check("t2_pop_req",   32'(imem_req), 32'd0);
    tick();
    check("t2_refill_req",  32'(imem_req), 32'd1);
    check("t2_refill_addr", imem_addr,     32'h10);
    tick();
    check("t2_refill_done", 32'(imem_req), 32'd0);
    check("t2_refill_acks", 32'(ack_cnt),  32'd5);

    // Redirect during a wait-stated request: old request drains, data dropped
    rst = 1'b0; run = 1'b0;
    tick();
    rst = 1'b1; run = 1'b1; ready = 1'b1; mem_wait = 3;
    tick();
    check("t3_addr0", imem_addr, 32'h0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("t3_drop_req",  32'(imem_req), 32'd1);
    check("t3_drop_addr", imem_addr,     32'h0);
    tick();
    check("t3_drop_addr2", imem_addr,  32'h0);
    check("t3_drop_valid", 32'(valid), 32'd0);
    tick();
    check("t3_new_req",   32'(imem_req), 32'd1);
    check("t3_new_addr",  imem_addr,     32'h100);
    check("t3_new_valid", 32'(valid),    32'd0);
    tick(); tick(); tick();
    check("t3_wait_valid", 32'(valid), 32'd0);
    tick();
    check("t3_dec_valid", 32'(valid), 32'd1);
    check("t3_dec_pc",    pc,         32'h100);
    check("t3_dec_instr", instr,      32'hDEAD_0100);

    // Redirect coinciding with ack and pop while two entries are queued
    rst = 1'b0; run = 1'b0; ready = 1'b0; mem_wait = 0;
    tick();
    rst = 1'b1; run = 1'b1;
    tick(); tick(); tick();
    check("t4_pre_pc",   pc,        32'h0);
    check("t4_pre_addr", imem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("t4_flush_valid", 32'(valid),    32'd0);
    check("t4_flush_pc",    pc,            32'h0);
    check("t4_flush_instr", instr,         32'h0);
    check("t4_new_req",     32'(imem_req), 32'd1);
    check("t4_new_addr",    imem_addr,     32'h200);
    tick();
    check("t4_dec_pc",    pc,    32'h200);
    check("t4_dec_instr", instr, 32'hDEAD_0200);

    // PC wrap at the top of the address space
    rst = 1'b0; run = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b1; run = 1'b1; ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
    tick();
    redirect = 1'b0;
    check("t5_addr_f8", imem_addr, 32'hFFFF_FFF8);
    tick();
    check("t5_addr_fc", imem_addr, 32'hFFFF_FFFC);
    check("t5_pc_f8",   pc,        32'hFFFF_FFF8);
    check("t5_ins_f8",  instr,     32'h2152_FFF8);
    tick();
    check("t5_addr_0",  imem_addr, 32'h0);
    check("t5_pc_fc",   pc,        32'hFFFF_FFFC);
    check("t5_ins_fc",  instr,     32'h2152_FFFC);
    tick();
    check("t5_addr_4",  imem_addr, 32'h4);
    check("t5_pc_0",    pc,        32'h0);

    // Run dropped while a request waits: it completes, then fetch stops
    rst = 1'b0; run = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b1; run = 1'b1; ready = 1'b1; mem_wait = 2;
    tick();
    run = 1'b0;
    check("t6_req0", 32'(imem_req), 32'd1);
    tick();
    check("t6_pend_req",  32'(imem_req), 32'd1);
    check("t6_pend_addr", imem_addr,     32'h0);
    tick(); tick();
    check("t6_done_req",   32'(imem_req), 32'd0);
    check("t6_done_valid", 32'(valid),    32'd1);
    check("t6_done_pc",    pc,            32'h0);
    check("t6_done_busy",  32'(busy),     32'd1);
    tick();
    check("t6_drain_valid", 32'(valid),    32'd0);
    check("t6_drain_busy",  32'(busy),     32'd0);
    tick();
    check("t6_stop_req",    32'(imem_req), 32'd0);
    run = 1'b1;
    tick();
    check("t6_resume_req",  32'(imem_req), 32'd1);
    check("t6_resume_addr", imem_addr,     32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
